mul_hilo_ctrl: RTL and testbench
================================

// Module: mul_hilo_ctrl
// PURPOSE
//  EX-stage multiply sequencer. Sits directly upstream of the combinational signed
//  multiplier and consumes its 64-bit product. Registers operands, holds the
//  pipeline while the product settles, corrects for unsigned ops, accumulates
//  (MADD/MSUB) and owns the architectural HI/LO registers (also MTHI/MTLO).
// PARAMETERS
//  DATA_WIDTH  32  operand width; HI/LO each DATA_WIDTH, product 2*DATA_WIDTH
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  start       in   1    valid multiply-class op from ID/EX this cycle
//  op          in   3    MUL_OP_* code (MULT, MULTU, MADD, MSUB, MTHI, MTLO)
//  op1, op2    in   DW   rs / rt values
//  flush       in   1    pipeline flush; aborts an in-flight op
//  mul_en      out  1    drive to multiplier
//  mul_op1/2   out  DW   registered operands to multiplier
//  mul_result  in   2DW  signed product from multiplier (combinational)
//  stall_req   out  1    hold IF/ID/EX while busy
//  busy        out  1    FSM not in IDLE
//  hi, lo      out  DW   architectural HI/LO (MFHI/MFLO read these directly)
// BEHAVIOUR
//  Reset: hi=lo=0, mul_op1/2=0, mul_en=0, stall_req=0, busy=0, state=IDLE.
//  FSM states IDLE, MUL, FIX:
//   IDLE: start & op in {MULT,MULTU,MADD,MSUB}: latch op1/op2/op -> MUL;
//         stall_req asserted combinationally in this cycle (cycle 0).
//         start & MTHI: hi<=op1; start & MTLO: lo<=op1; no stall, stay IDLE.
//   MUL (cycle 1): mul_en=1; mul_result registered into prod at cycle end -> FIX.
//   FIX (cycle 2): compute r, write {hi,lo}; stall_req=1 this cycle; -> IDLE.
//  Latency: HI/LO visible cycle 3; stall_req high exactly cycles 0,1,2.
//  Arithmetic (all mod 2^(2DW)):
//   s = prod (signed product).
//   MULTU: r = s + (a[DW-1] ? b<<DW : 0) + (b[DW-1] ? a<<DW : 0).
//   MULT:  r = s.   MADD: r = {hi,lo} + s.   MSUB: r = {hi,lo} - s.
//   MADD/MSUB signed only; carry out of bit 2DW-1 discarded.
//  Boundary rules:
//   start while busy: ignored (upstream is stalled; must not occur).
//   flush in any state: -> IDLE next edge, HI/LO unchanged, stall_req drops
//     next cycle; flush in IDLE with start: op discarded (MTHI/MTLO included).
//   flush and FIX in same cycle: flush wins, no HI/LO write.
//   rst_n low mid-op: immediate return to reset values, no write.
//   mul_en low in IDLE; mul_op1/2 hold last values (no toggling when idle).
//   Unknown op code with start: treated as NOP, no stall.
// STRUCTURE
//  Shared header (funct.v style): MUL_OP_MULT=0, MULTU=1, MADD=2, MSUB=3,
//   MTHI=4, MTLO=5; state encodings MST_IDLE/MUL/FIX; widths from bus.v.
//  One sub-module natural: hilo_reg (hi/lo storage, write-enable, async reset).
//  Multiplier is instantiated by the EX top, not inside this block.
// TESTING
//  Bench instantiates this block plus the multiplier; checks stall_req timing.
//  MULT 0xFFFFFFFF*0x00000002 -> hi=FFFFFFFF lo=FFFFFFFE at cycle 3, stall 3 cycles.
//  MULTU 0xFFFFFFFF*0x00000002 -> hi=00000001 lo=FFFFFFFE;
//   MULTU 0x80000000*0x80000000 -> hi=40000000 lo=00000000.
//  MTLO 0x10, then MADD 3*4 -> hi=0 lo=0000001C;
//   MTLO 5, MTHI 0, MSUB 2*3 -> hi=FFFFFFFF lo=FFFFFFFF.
//  MULT 7*9 with flush in MUL and again in FIX -> hi/lo unchanged, stall ends next cycle.
//  rst_n pulled low in MUL after hi/lo=1234/5678 -> hi=lo=0, busy=0 immediately.
//  Back-to-back: MULT then MTHI issued the cycle after stall drops -> both applied in order.

Source files
------------

// File: rtl/mul_hilo_ctrl_pkg.sv
// mul_hilo_ctrl_pkg: shared op codes, FSM encodings and default width for the multiply sequencer
package mul_hilo_ctrl_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam logic [2:0] MUL_OP_MULT  = 3'd0;
   localparam logic [2:0] MUL_OP_MULTU = 3'd1;
   localparam logic [2:0] MUL_OP_MADD  = 3'd2;
   localparam logic [2:0] MUL_OP_MSUB  = 3'd3;
   localparam logic [2:0] MUL_OP_MTHI  = 3'd4;
   localparam logic [2:0] MUL_OP_MTLO  = 3'd5;
   localparam logic [1:0] MST_IDLE = 2'd0;
   localparam logic [1:0] MST_MUL  = 2'd1;
   localparam logic [1:0] MST_FIX  = 2'd2;
   function automatic logic is_mul_op(input logic [2:0] op);
      return op <= MUL_OP_MSUB;
   endfunction
endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// mul_hilo_ctrl_if: ID/EX-side issue bus and HI/LO/stall return for the multiply sequencer
interface mul_hilo_ctrl_if #(parameter int DW = 32);
   logic          start;
   logic [2:0]    op;
   logic [DW-1:0] op1;
   logic [DW-1:0] op2;
   logic          flush;
   logic          stall_req;
   logic          busy;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;
   modport master (output start, op, op1, op2, flush, input stall_req, busy, hi, lo);
   modport slave (input start, op, op1, op2, flush, output stall_req, busy, hi, lo);
endinterface

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// mul_hilo_ctrl_hilo_reg: architectural HI/LO storage with independent write enables
module mul_hilo_ctrl_hilo_reg #(parameter int DW = 32) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_hi,
   input  logic          we_lo,
   input  logic [DW-1:0] d_hi,
   input  logic [DW-1:0] d_lo,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo
);
   // hold HI/LO, load each half only when its enable is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (we_hi) hi <= d_hi;
         if (we_lo) lo <= d_lo;
      end
   end
endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: EX-stage multiply sequencer driving an external signed multiplier and owning HI/LO
module mul_hilo_ctrl
   import mul_hilo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mul_hilo_ctrl_if.slave          bus,
   output logic                    mul_en,
   output logic [DATA_WIDTH-1:0]   mul_op1,
   output logic [DATA_WIDTH-1:0]   mul_op2,
   input  logic [2*DATA_WIDTH-1:0] mul_result
);
   localparam int DW = DATA_WIDTH;
   logic [1:0]      state;
   logic [1:0]      state_nx;
   logic [2:0]      op_q;
   logic [2*DW-1:0] prod;
   logic [2*DW-1:0] acc;
   logic [2*DW-1:0] fix;
   logic [2*DW-1:0] r;
   logic            idle;
   logic            take;
   logic            issue;
   logic            wr_fix;
   logic            we_hi;
   logic            we_lo;
   logic [DW-1:0]   d_hi;
   logic [DW-1:0]   d_lo;
   assign idle   = state == MST_IDLE;
   assign take   = idle & bus.start & ~bus.flush;
   assign issue  = take & is_mul_op(bus.op);
   assign wr_fix = (state == MST_FIX) & ~bus.flush;
   assign mul_en = state == MST_MUL;
   assign bus.busy      = ~idle;
   assign bus.stall_req = ~idle | issue;
   // next state: flush always returns to IDLE, otherwise IDLE->MUL->FIX->IDLE
   always_comb begin
      state_nx = bus.flush ? MST_IDLE : issue ? MST_MUL : (state == MST_MUL) ? MST_FIX : MST_IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MST_IDLE;
      else        state <= state_nx;
   end
   // operands and op latched on issue only, so the multiplier inputs stay quiet when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_op1 <= '0;
         mul_op2 <= '0;
         op_q    <= MUL_OP_MULT;
      end else if (issue) begin
         mul_op1 <= bus.op1;
         mul_op2 <= bus.op2;
         op_q    <= bus.op;
      end
   end
   // capture the settled product at the end of the MUL cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                prod <= '0;
      else if (state == MST_MUL) prod <= mul_result;
   end
   // unsigned correction adds back the operand weights lost by signed interpretation
   always_comb begin
      acc = {bus.hi, bus.lo};
      fix = (mul_op1[DW-1] ? {mul_op2, {DW{1'b0}}} : '0) + (mul_op2[DW-1] ? {mul_op1, {DW{1'b0}}} : '0);
      r   = (op_q == MUL_OP_MULTU) ? prod + fix :
            (op_q == MUL_OP_MADD)  ? acc + prod :
            (op_q == MUL_OP_MSUB)  ? acc - prod : prod;
   end
   // HI/LO write source: FIX result, or direct MTHI/MTLO from IDLE
   always_comb begin
      we_hi = wr_fix | (take & (bus.op == MUL_OP_MTHI));
      we_lo = wr_fix | (take & (bus.op == MUL_OP_MTLO));
      d_hi  = wr_fix ? r[2*DW-1:DW] : bus.op1;
      d_lo  = wr_fix ? r[DW-1:0] : bus.op1;
   end
   mul_hilo_ctrl_hilo_reg #(.DW(DW)) u_hilo (
      .clk   (clk),
      .rst_n (rst_n),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .d_hi  (d_hi),
      .d_lo  (d_lo),
      .hi    (bus.hi),
      .lo    (bus.lo)
   );
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb_mul_hilo_ctrl: directed-vector bench for the multiply sequencer with a behavioural signed multiplier
module tb_mul_hilo_ctrl;
   import mul_hilo_ctrl_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mul_en;
   logic [31:0] mul_op1;
   logic [31:0] mul_op2;
   logic [63:0] mul_result;
   int          vecs = 0;
   int          errs = 0;
   mul_hilo_ctrl_if #(.DW(32)) bus ();
   mul_hilo_ctrl #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mul_en     (mul_en),
      .mul_op1    (mul_op1),
      .mul_op2    (mul_op2),
      .mul_result (mul_result)
   );
   assign mul_result = $signed({{32{mul_op1[31]}}, mul_op1}) * $signed({{32{mul_op2[31]}}, mul_op2});
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      bus.start = 0; bus.op = 0; bus.op1 = 0; bus.op2 = 0; bus.flush = 0;
      rst_n = 0;
      #1;
      vecs++; if (bus.hi !== 32'h0) begin errs++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
      vecs++; if (bus.lo !== 32'h0) begin errs++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
      vecs++; if ({mul_op1, mul_op2} !== 64'h0) begin errs++; $display("FAIL reset_ops: got %h expected 0", {mul_op1, mul_op2}); end
      vecs++; if ({mul_en, bus.stall_req, bus.busy} !== 3'b000) begin errs++; $display("FAIL reset_ctl: got %b expected 000", {mul_en, bus.stall_req, bus.busy}); end
      @(negedge clk); rst_n = 1;
      @(negedge clk); #1;
   endtask

   task automatic run_mul(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
      bus.start = 1; bus.op = op; bus.op1 = a; bus.op2 = b;
      #1;
      vecs++; if (bus.stall_req !== 1'b1) begin errs++; $display("FAIL %s_stall_c0: got %b expected 1", name, bus.stall_req); end
      @(negedge clk); bus.start = 0; bus.op1 = 32'hDEAD_BEEF; bus.op2 = 32'hCAFE_F00D; #1;
      vecs++; if ({bus.stall_req, bus.busy, mul_en} !== 3'b111) begin errs++; $display("FAIL %s_c1: got %b expected 111", name, {bus.stall_req, bus.busy, mul_en}); end
      @(negedge clk); #1;
      vecs++; if ({bus.stall_req, bus.busy, mul_en} !== 3'b110) begin errs++; $display("FAIL %s_c2: got %b expected 110", name, {bus.stall_req, bus.busy, mul_en}); end
      @(negedge clk); #1;
      vecs++; if ({bus.stall_req, bus.busy} !== 2'b00) begin errs++; $display("FAIL %s_c3: got %b expected 00", name, {bus.stall_req, bus.busy}); end
      vecs++; if ({bus.hi, bus.lo} !== {ehi, elo}) begin errs++; $display("FAIL %s_hilo: got %h_%h expected %h_%h", name, bus.hi, bus.lo, ehi, elo); end
      vecs++; if ({mul_op1, mul_op2} !== {a, b}) begin errs++; $display("FAIL %s_hold: got %h_%h expected %h_%h", name, mul_op1, mul_op2, a, b); end
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] v);
      bus.start = 1; bus.op = op; bus.op1 = v;
      #1;
      vecs++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL mt_stall: got %b expected 0", bus.stall_req); end
      @(negedge clk); bus.start = 0; bus.op1 = 0; #1;
   endtask

   task automatic test_mult;
      run_mul("mult_neg", MUL_OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_mul("mult_pos", MUL_OP_MULT, 32'd7, 32'd9, 32'h0, 32'h3F);
   endtask

   task automatic test_multu;
      run_mul("multu_a", MUL_OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
      run_mul("multu_b", MUL_OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
   endtask

   task automatic test_madd_msub;
      do_mt(MUL_OP_MTHI, 32'h0);
      do_mt(MUL_OP_MTLO, 32'h10);
      chk("mtlo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0010);
      run_mul("madd", MUL_OP_MADD, 32'd3, 32'd4, 32'h0, 32'h1C);
      do_mt(MUL_OP_MTLO, 32'h5);
      do_mt(MUL_OP_MTHI, 32'h0);
      run_mul("msub", MUL_OP_MSUB, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_flush;
      do_mt(MUL_OP_MTHI, 32'h11);
      do_mt(MUL_OP_MTLO, 32'h22);
      bus.start = 1; bus.op = MUL_OP_MULT; bus.op1 = 7; bus.op2 = 9;
      @(negedge clk); bus.start = 0; bus.flush = 1; #1;
      chk("flush_mul_stall", bus.stall_req, 1);
      @(negedge clk); bus.flush = 0; #1;
      chk("flush_mul_drop", {bus.stall_req, bus.busy}, 0);
      bus.start = 1; bus.op = MUL_OP_MULT;
      @(negedge clk); bus.start = 0; #1;
      @(negedge clk); bus.flush = 1; #1;
      chk("flush_fix_stall", bus.stall_req, 1);
      @(negedge clk); bus.flush = 0; #1;
      chk("flush_fix_drop", {bus.stall_req, bus.busy}, 0);
      chk("flush_hilo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
      bus.start = 1; bus.op = MUL_OP_MTHI; bus.op1 = 32'h99; bus.flush = 1; #1;
      chk("flush_idle_mt_stall", bus.stall_req, 0);
      @(negedge clk); bus.op = MUL_OP_MULT; #1;
      chk("flush_idle_mul_stall", bus.stall_req, 0);
      @(negedge clk); bus.start = 0; bus.flush = 0; #1;
      chk("flush_idle_busy", bus.busy, 0);
      chk("flush_idle_hilo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
   endtask

   task automatic test_unknown_op;
      bus.start = 1; bus.op = 3'd7; bus.op1 = 32'h55; bus.op2 = 32'h66; #1;
      chk("unk_stall", bus.stall_req, 0);
      @(negedge clk); bus.start = 0; #1;
      chk("unk_busy", {bus.busy, mul_en}, 0);
      chk("unk_hilo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
   endtask

   task automatic test_async_reset;
      do_mt(MUL_OP_MTHI, 32'h1234);
      do_mt(MUL_OP_MTLO, 32'h5678);
      bus.start = 1; bus.op = MUL_OP_MULT; bus.op1 = 7; bus.op2 = 9;
      @(negedge clk); bus.start = 0; #1;
      chk("rst_pre_mul_en", mul_en, 1);
      rst_n = 0; #1;
      chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("rst_mid_ctl", {bus.busy, bus.stall_req, mul_en}, 0);
      chk("rst_mid_ops", {mul_op1, mul_op2}, 64'h0);
      @(negedge clk); rst_n = 1;
      @(negedge clk); #1;
      chk("rst_after_hilo", {bus.hi, bus.lo}, 64'h0);
   endtask

   task automatic test_back_to_back;
      run_mul("b2b_mult", MUL_OP_MULT, 32'd3, 32'd5, 32'h0, 32'hF);
      do_mt(MUL_OP_MTHI, 32'hAA);
      chk("b2b_hilo", {bus.hi, bus.lo}, 64'h0000_00AA_0000_000F);
      run_mul("b2b_again", MUL_OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6);
   endtask

   initial begin
      test_reset;
      test_mult;
      test_multu;
      test_madd_msub;
      test_flush;
      test_unknown_op;
      test_async_reset;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
